// File: rtl/lza_string_encoder.sv
// LZA string encoder: n/z/p digit strings and one-sided leading-zero
// predictions for A-B and B-A, in a 2-stage valid/ready pipeline.
module lza_string_encoder #(
   parameter  int DATA_WIDTH = 8,
   localparam int LZC_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] op_a,
   input  logic [DATA_WIDTH-1:0] op_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] string_n_pos,
   output logic [DATA_WIDTH-1:0] string_z_pos,
   output logic [DATA_WIDTH-1:0] string_p_pos,
   output logic [DATA_WIDTH-1:0] string_n_neg,
   output logic [DATA_WIDTH-1:0] string_z_neg,
   output logic [DATA_WIDTH-1:0] string_p_neg,
   output logic [LZC_WIDTH-1:0]  lzc_pos,
   output logic [LZC_WIDTH-1:0]  lzc_neg,
   output logic                  all_zero
);

   logic                  s1_valid;
   logic [DATA_WIDTH-1:0] s1_n;
   logic [DATA_WIDTH-1:0] s1_z;
   logic [DATA_WIDTH-1:0] s1_p;

   logic                  s2_free;
   logic                  s1_adv;
   logic                  in_fire;
   logic [DATA_WIDTH-1:0] f_pos;
   logic [DATA_WIDTH-1:0] f_neg;
   logic [LZC_WIDTH-1:0]  lzc_pos_d;
   logic [LZC_WIDTH-1:0]  lzc_neg_d;

   function automatic logic [LZC_WIDTH-1:0] lead_zeros(
      input logic [DATA_WIDTH-1:0] f
   );
      lead_zeros = LZC_WIDTH'(DATA_WIDTH);
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (f[i]) lead_zeros = LZC_WIDTH'(DATA_WIDTH - 1 - i);
      end
   endfunction

   assign s2_free  = !out_valid || out_ready;
   assign s1_adv   = s1_valid && s2_free;
   assign in_ready = !s1_valid || s1_adv;
   assign in_fire  = in_valid && in_ready;

   // Digit below the LSB counts as z, so a zero is shifted in.
   assign f_pos = ~s1_z & ~{s1_n[DATA_WIDTH-2:0], 1'b0};
   assign f_neg = ~s1_z & ~{s1_p[DATA_WIDTH-2:0], 1'b0};

   always_comb begin
      lzc_pos_d = lead_zeros(f_pos);
      lzc_neg_d = lead_zeros(f_neg);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_n     <= '0;
         s1_z     <= '0;
         s1_p     <= '0;
      end else begin
         if (in_fire) begin
            s1_valid <= 1'b1;
            s1_n     <= ~op_a & op_b;
            s1_z     <= ~(op_a ^ op_b);
            s1_p     <= op_a & ~op_b;
         end else if (s1_adv) begin
            s1_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         string_n_pos <= '0;
         string_z_pos <= '0;
         string_p_pos <= '0;
         string_n_neg <= '0;
         string_z_neg <= '0;
         string_p_neg <= '0;
         lzc_pos      <= '0;
         lzc_neg      <= '0;
         all_zero     <= 1'b0;
      end else begin
         if (s1_adv) begin
            out_valid    <= 1'b1;
            string_n_pos <= s1_n;
            string_z_pos <= s1_z;
            string_p_pos <= s1_p;
            string_n_neg <= s1_p;
            string_z_neg <= s1_z;
            string_p_neg <= s1_n;
            lzc_pos      <= lzc_pos_d;
            lzc_neg      <= lzc_neg_d;
            all_zero     <= &s1_z;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lza_string_encoder.sv
// Scoreboard bench for lza_string_encoder: directed cases, stall,
// mid-flight reset and a randomized stream against a reference model.
module tb_lza_string_encoder;

   localparam int W = 8;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] n;
      logic [7:0] z;
      logic [7:0] p;
      logic [3:0] lp;
      logic [3:0] ln;
      logic       az;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] op_a = '0;
   logic [7:0] op_b = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] string_n_pos, string_z_pos, string_p_pos;
   logic [7:0] string_n_neg, string_z_neg, string_p_neg;
   logic [3:0] lzc_pos, lzc_neg;
   logic       all_zero;

   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   bit   rnd_ready = 1'b0;

   lza_string_encoder #(.DATA_WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .string_n_pos(string_n_pos), .string_z_pos(string_z_pos),
      .string_p_pos(string_p_pos), .string_n_neg(string_n_neg),
      .string_z_neg(string_z_neg), .string_p_neg(string_p_neg),
      .lzc_pos(lzc_pos), .lzc_neg(lzc_neg), .all_zero(all_zero)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      bit   fp, fn;
      e.a = a;
      e.b = b;
      e.n = ~a & b;
      e.z = ~(a ^ b);
      e.p = a & ~b;
      e.lp = 4'd8;
      e.ln = 4'd8;
      fp = 0;
      fn = 0;
      for (int i = 7; i >= 0; i--) begin
         logic nb, pb;
         nb = (i == 0) ? 1'b0 : e.n[i-1];
         pb = (i == 0) ? 1'b0 : e.p[i-1];
         if (!fp && !e.z[i] && !nb) begin fp = 1; e.lp = 4'(7 - i); end
         if (!fn && !e.z[i] && !pb) begin fn = 1; e.ln = 4'(7 - i); end
      end
      e.az = (a == b);
      return e;
   endfunction

   function automatic int true_lzc(input logic [7:0] a, input logic [7:0] b);
      int d, c;
      d = (a >= b) ? int'(a) - int'(b) : int'(b) - int'(a);
      c = 0;
      while (c < 8 && d < (1 << (7 - c))) c++;
      return c;
   endfunction

   function automatic exp_t fixed(input logic [7:0] a, b, n, z, p,
                                  input logic [3:0] lp, ln, input logic az);
      exp_t e;
      e.a = a; e.b = b; e.n = n; e.z = z; e.p = p;
      e.lp = lp; e.ln = ln; e.az = az;
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] got,
                      input logic [63:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got=%h required=%h", name, got, req);
      end
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b,
                       input exp_t e);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      op_a = a;
      op_b = b;
      #1;
      while (!in_ready && n < 1000) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 64'd0, 64'd1);
         in_valid = 1'b0;
      end else begin
         q.push_back(e);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
   endtask

   always @(negedge clk) begin
      if (rnd_ready) out_ready = ($urandom % 4) != 0;
   end

   initial begin : monitor
      logic [56:0] snap, cur;
      bit          hold = 0;
      exp_t        e;
      int          t, lx;
      forever begin
         @(negedge clk);
         #2;
         cur = {string_n_pos, string_z_pos, string_p_pos, string_n_neg,
                string_z_neg, string_p_neg, lzc_pos, lzc_neg, all_zero};
         if (!rst_n) begin
            hold = 0;
         end else begin
            if (hold) begin
               chk("hold_valid", 64'(out_valid), 64'd1);
               chk("hold_data", 64'(cur), 64'(snap));
            end
            hold = out_valid && !out_ready;
            snap = cur;
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  chk("unexpected_beat", 64'd1, 64'd0);
               end else begin
                  e = q.pop_front();
                  chk("strings",
                      64'({string_n_pos, string_z_pos, string_p_pos,
                           string_n_neg, string_z_neg, string_p_neg}),
                      64'({e.n, e.z, e.p, e.p, e.z, e.n}));
                  chk("lzc", 64'({lzc_pos, lzc_neg}), 64'({e.lp, e.ln}));
                  chk("all_zero", 64'(all_zero), 64'(e.az));
                  t = true_lzc(e.a, e.b);
                  lx = (e.a >= e.b) ? int'(lzc_pos) : int'(lzc_neg);
                  chk("lza_bound", 64'(((t - lx) == 0) || ((t - lx) == 1)),
                      64'd1);
               end
            end
         end
      end
   end

   initial begin
      bit seen_low;
      logic [7:0] a, b;
      #2;
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      chk("reset_outputs",
          64'({string_n_pos, string_z_pos, string_p_pos, lzc_pos, all_zero}),
          64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;

      send(8'h40, 8'h3F, fixed(8'h40, 8'h3F, 8'h3F, 8'h80, 8'h40, 4'd7, 4'd1, 1'b0));
      send(8'h80, 8'h01, fixed(8'h80, 8'h01, 8'h01, 8'h7E, 8'h80, 4'd0, 4'd0, 1'b0));
      send(8'h5A, 8'h5A, fixed(8'h5A, 8'h5A, 8'h00, 8'hFF, 8'h00, 4'd8, 4'd8, 1'b1));
      drain();

      // Back-to-back stream with a 3-cycle consumer stall.
      seen_low = 0;
      @(negedge clk);
      fork
         begin
            send(8'h11, 8'h22, model(8'h11, 8'h22));
            send(8'h33, 8'h30, model(8'h33, 8'h30));
            send(8'h7F, 8'h80, model(8'h7F, 8'h80));
            send(8'hC4, 8'h0B, model(8'hC4, 8'h0B));
         end
         begin
            for (int c = 1; c <= 8; c++) begin
               @(negedge clk);
               out_ready = !(c >= 3 && c <= 5);
               #1;
               if (!in_ready) seen_low = 1;
            end
         end
      join
      chk("stall_in_ready_low", 64'(seen_low), 64'd1);
      out_ready = 1'b1;
      drain();

      // Reset with two beats in flight.
      @(negedge clk);
      out_ready = 1'b0;
      send(8'h12, 8'h34, model(8'h12, 8'h34));
      send(8'h56, 8'h78, model(8'h56, 8'h78));
      @(negedge clk);
      rst_n = 1'b0;
      q.delete();
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_outputs",
          64'({string_n_pos, string_z_pos, string_p_pos, string_n_neg,
               string_z_neg, string_p_neg, lzc_pos, lzc_neg, all_zero}),
          64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b1;
      op_a = 8'h9C;
      op_b = 8'h9D;
      #1;
      chk("post_rst_accept", 64'(in_ready), 64'd1);
      q.push_back(model(8'h9C, 8'h9D));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("latency_c1", 64'(out_valid), 64'd0);
      @(negedge clk);
      #1;
      chk("latency_c2", 64'(out_valid), 64'd1);
      drain();

      // Randomized stream with random consumer backpressure.
      rnd_ready = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         a = 8'($urandom);
         b = ($urandom % 8 == 0) ? a : 8'($urandom);
         send(a, b, model(a, b));
      end
      drain();
      rnd_ready = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
